mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port byte-addressable data/instruction memory between two requesters: the instruction-fetch port (I, read-only) and the load/store port (D, read/write with byte mask).
- Sits between the core front-end/LSU and the memory block; drives its address, wdata, mask and wren, and registers its combinational read data into a one-cycle-latency response per port.
- D has fixed priority, with an anti-starvation override for I and a bounded lock so the LSU can run atomic multi-access sequences.

Parameters:
- ADDR_W, 11, memory byte-address width.
- MAX_STARVE, 4, consecutive cycles I may be denied while requesting before it wins the next conflict (1..15).
- LOCK_MAX, 8, maximum cycles a D lock may hold the memory before forced release (1..15).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_i_valid  in  1  I read request
- i_i_addr  in  ADDR_W  I byte address
- o_i_ready  out  1  I request accepted this cycle
- o_i_rvalid  out  1  I response valid (one-cycle pulse)
- o_i_rdata  out  32  I read data
- i_d_valid  in  1  D request
- i_d_addr  in  ADDR_W  D byte address
- i_d_wdata  in  32  D write data
- i_d_mask  in  4  D byte-lane mask
- i_d_wren  in  1  D write (1) / read (0)
- i_d_lock  in  1  hold grant after this D access
- o_d_ready  out  1  D request accepted this cycle
- o_d_rvalid  out  1  D response valid (reads and write acks)
- o_d_rdata  out  32  D read data (0 for writes)
- o_mem_addr  out  ADDR_W  to memory
- o_mem_wdata  out  32  to memory
- o_mem_mask  out  4  to memory
- o_mem_wren  out  1  to memory
- i_mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (i_reset=0 at posedge): FSM to ARB_IDLE; starve counter, lock counter, o_i_rvalid, o_d_rvalid, o_i_rdata, o_d_rdata all 0. While i_reset is low, o_i_ready=o_d_ready=0 and o_mem_wren=0.
- Transfer occurs when valid and ready are both high; at most one transfer per cycle. Ready is combinational from valid and state; requesters hold request fields stable until ready.
- Memory drive: the granted port's fields are driven. For I: mask=4'hF, wren=0. No grant: addr/wdata/mask=0, wren=0.
- Response: the posedge after a transfer sets the granted port's rvalid=1 and rdata=i_mem_rdata (D write: rdata=0). rvalid is a single-cycle pulse; there is no response backpressure. Back-to-back transfers give back-to-back pulses.
- FSM ARB_IDLE:
  - Only one port valid: grant it.
  - Both valid: grant D, unless starve_cnt >= MAX_STARVE, in which case grant I.
  - If D is granted with i_d_lock=1, go to ARB_LOCKED with lock_cnt=1.
- FSM ARB_LOCKED:
  - Only D may be granted; I is never granted.
  - Each cycle, lock_cnt increments.
  - Leave to ARB_IDLE when a D transfer carries i_d_lock=0, or when lock_cnt reaches LOCK_MAX (forced release; a D transfer in that cycle still completes).
- starve_cnt (4 bits, saturating):
  - increments each cycle i_i_valid=1 and o_i_ready=0;
  - clears on an I transfer or when i_i_valid=0.
- Boundary conditions:
  - Reset mid-lock: return to ARB_IDLE; in-flight rvalid is dropped.
  - Lock requested in the same cycle I wins by starvation: the lock is ignored (D not granted).
  - Address arithmetic and wrap are owned by the memory; the arbiter passes the address unchanged.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds three 16-bit saturating outputs:
  - o_stat_i_grants: I transfers.
  - o_stat_d_grants: D transfers.
  - o_stat_conflicts: cycles with both valid.
  - All three reset to 0.
- MEM_ARB_STATS_EN undefined: these ports and counters do not exist.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_e enum (ARB_IDLE, ARB_LOCKED);
  - port index constants PORT_I=0, PORT_D=1;
  - MASK_WORD=4'hF.
- One sub-module, mem_arb_rsp_reg: per-port response register (rvalid pulse and rdata capture), instantiated twice.

Test Plan:
- I only, addr 0x010, memory holds 0xDEADBEEF -> o_i_ready same cycle; next cycle o_i_rvalid=1, o_i_rdata=0xDEADBEEF; mem mask=4'hF, wren=0.
- D write addr 0x020, wdata 0x11223344, mask 4'b0011, wren=1 -> mem driven with those values; next cycle o_d_rvalid=1, o_d_rdata=0.
- Both valid continuously, MAX_STARVE=4 -> D granted cycles 0-3; I granted cycle 4; starve_cnt cleared; D resumes cycle 5.
- D lock on 3 accesses (lock=1,1,0) with I valid throughout -> I never ready during the sequence; I granted the cycle after the lock=0 transfer.
- D holds lock=1 with LOCK_MAX=8 -> forced release after 8 cycles; I granted on the next cycle.
- i_reset=0 asserted while in ARB_LOCKED with an rvalid pending -> next cycle state ARB_IDLE, all rvalid=0, readies 0 while reset is low.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  localparam logic [3:0] MASK_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_rsp_reg.sv
// One-cycle response register: turns a transfer into an rvalid pulse and
// captures the read data presented in the transfer cycle.
module mem_arb_rsp_reg (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_xfer,
  input  logic [31:0] i_data,
  output logic        o_rvalid,
  output logic [31:0] o_rdata
);

  // rdata holds its last value between pulses; only rvalid qualifies it
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= i_xfer;
      if (i_xfer) o_rdata <= i_data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port memory: D has priority, I gets
// a starvation override, D may lock the memory for a bounded run of cycles.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int MAX_STARVE = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_i_valid,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic              o_i_ready,
  output logic              o_i_rvalid,
  output logic [31:0]       o_i_rdata,
  input  logic              i_d_valid,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [3:0]        i_d_mask,
  input  logic              i_d_wren,
  input  logic              i_d_lock,
  output logic              o_d_ready,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       o_stat_i_grants,
  output logic [15:0]       o_stat_d_grants,
  output logic [15:0]       o_stat_conflicts
`endif
);

  arb_state_e  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [3:0]  lock_q, lock_d;
  logic [1:0]  grant;
  logic        starved;
  logic [31:0] d_rsp_data;

  assign starved = (starve_q >= 4'(MAX_STARVE));

  always_comb begin
    grant   = '0;
    state_d = state_q;
    lock_d  = lock_q;
    if (i_reset) begin
      case (state_q)
        ARB_IDLE: begin
          if (i_d_valid && !(i_i_valid && starved)) grant[PORT_D] = 1'b1;
          else if (i_i_valid)                        grant[PORT_I] = 1'b1;
          if (grant[PORT_D] && i_d_lock) begin
            state_d = ARB_LOCKED;
            lock_d  = 4'd1;
          end else begin
            lock_d  = '0;
          end
        end
        ARB_LOCKED: begin
          grant[PORT_D] = i_d_valid;
          // Forced release still lets the D transfer of the final cycle complete
          if ((grant[PORT_D] && !i_d_lock) || (lock_q >= 4'(LOCK_MAX))) begin
            state_d = ARB_IDLE;
            lock_d  = '0;
          end else begin
            lock_d  = lock_q + 4'd1;
          end
        end
        default: begin
          state_d = ARB_IDLE;
          lock_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_i_valid || grant[PORT_I]) starve_d = '0;
    else if (starve_q != 4'hF)       starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    o_mem_wren  = 1'b0;
    if (grant[PORT_D]) begin
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
      o_mem_mask  = i_d_mask;
      o_mem_wren  = i_d_wren;
    end else if (grant[PORT_I]) begin
      o_mem_addr  = i_i_addr;
      o_mem_mask  = MASK_WORD;
    end
  end

  assign o_i_ready  = grant[PORT_I];
  assign o_d_ready  = grant[PORT_D];
  assign d_rsp_data = i_d_wren ? 32'h0 : i_mem_rdata;

  mem_arb_rsp_reg u_rsp_i (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_xfer   (grant[PORT_I]),
    .i_data   (i_mem_rdata),
    .o_rvalid (o_i_rvalid),
    .o_rdata  (o_i_rdata)
  );

  mem_arb_rsp_reg u_rsp_d (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_xfer   (grant[PORT_D]),
    .i_data   (d_rsp_data),
    .o_rvalid (o_d_rvalid),
    .o_rdata  (o_d_rdata)
  );

`ifdef MEM_ARB_STATS_EN
  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_stat_i_grants  <= '0;
      o_stat_d_grants  <= '0;
      o_stat_conflicts <= '0;
    end else begin
      if (grant[PORT_I] && o_stat_i_grants != 16'hFFFF)
        o_stat_i_grants <= o_stat_i_grants + 16'd1;
      if (grant[PORT_D] && o_stat_d_grants != 16'hFFFF)
        o_stat_d_grants <= o_stat_d_grants + 16'd1;
      if (i_i_valid && i_d_valid && o_stat_conflicts != 16'hFFFF)
        o_stat_conflicts <= o_stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small word memory model.
module tb_mem_arbiter;

  localparam int ADDR_W = 11;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_i_valid;
  logic [ADDR_W-1:0] i_i_addr;
  logic              o_i_ready;
  logic              o_i_rvalid;
  logic [31:0]       o_i_rdata;
  logic              i_d_valid;
  logic [ADDR_W-1:0] i_d_addr;
  logic [31:0]       i_d_wdata;
  logic [3:0]        i_d_mask;
  logic              i_d_wren;
  logic              i_d_lock;
  logic              o_d_ready;
  logic              o_d_rvalid;
  logic [31:0]       o_d_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_mask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]       o_stat_i_grants;
  logic [15:0]       o_stat_d_grants;
  logic [15:0]       o_stat_conflicts;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_model [0:511];

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(4), .LOCK_MAX(8)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_i_valid   (i_i_valid),
    .i_i_addr    (i_i_addr),
    .o_i_ready   (o_i_ready),
    .o_i_rvalid  (o_i_rvalid),
    .o_i_rdata   (o_i_rdata),
    .i_d_valid   (i_d_valid),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .i_d_mask    (i_d_mask),
    .i_d_wren    (i_d_wren),
    .i_d_lock    (i_d_lock),
    .o_d_ready   (o_d_ready),
    .o_d_rvalid  (o_d_rvalid),
    .o_d_rdata   (o_d_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_mask  (o_mem_mask),
    .o_mem_wren  (o_mem_wren),
    .i_mem_rdata (i_mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .o_stat_i_grants  (o_stat_i_grants),
    .o_stat_d_grants  (o_stat_d_grants),
    .o_stat_conflicts (o_stat_conflicts)
`endif
  );

  // Combinational-read memory; contents reload whenever reset is held
  assign i_mem_rdata = mem_model[o_mem_addr[ADDR_W-1:2]];

  always @(posedge i_clk) begin
    if (!i_reset) begin
      mem_model[0] <= 32'h0;
      mem_model[4] <= 32'hDEADBEEF;
      mem_model[8] <= 32'hAAAAAAAA;
    end else if (o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_mask[b])
          mem_model[o_mem_addr[ADDR_W-1:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then settles before checks
  task automatic applyStimulus(input logic rst_n, input logic iv, input logic [ADDR_W-1:0] ia,
                               input logic dv, input logic [ADDR_W-1:0] da,
                               input logic [31:0] wd, input logic [3:0] m,
                               input logic we, input logic lk);
    @(negedge i_clk);
    i_reset   = rst_n;
    i_i_valid = iv;
    i_i_addr  = ia;
    i_d_valid = dv;
    i_d_addr  = da;
    i_d_wdata = wd;
    i_d_mask  = m;
    i_d_wren  = we;
    i_d_lock  = lk;
    #1;
  endtask

  initial begin
    i_reset = 1'b0; i_i_valid = 1'b0; i_i_addr = '0; i_d_valid = 1'b0; i_d_addr = '0;
    i_d_wdata = '0; i_d_mask = '0; i_d_wren = 1'b0; i_d_lock = 1'b0;

    // Reset with both requesters active
    applyStimulus(1'b0, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b1, 1'b0);
    checkOutput("rst_i_ready",  32'(o_i_ready),  32'd0);
    checkOutput("rst_d_ready",  32'(o_d_ready),  32'd0);
    checkOutput("rst_mem_wren", 32'(o_mem_wren), 32'd0);
    checkOutput("rst_mem_addr", 32'(o_mem_addr), 32'h0);
    checkOutput("rst_i_rvalid", 32'(o_i_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(o_d_rvalid), 32'd0);
    checkOutput("rst_i_rdata",  o_i_rdata,       32'h0);
    checkOutput("rst_d_rdata",  o_d_rdata,       32'h0);
    applyStimulus(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // I-only read
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("ionly_i_ready",  32'(o_i_ready),  32'd1);
    checkOutput("ionly_d_ready",  32'(o_d_ready),  32'd0);
    checkOutput("ionly_mem_addr", 32'(o_mem_addr), 32'h010);
    checkOutput("ionly_mem_mask", 32'(o_mem_mask), 32'hF);
    checkOutput("ionly_mem_wren", 32'(o_mem_wren), 32'd0);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("ionly_i_rvalid", 32'(o_i_rvalid), 32'd1);
    checkOutput("ionly_i_rdata",  o_i_rdata,       32'hDEADBEEF);
    checkOutput("ionly_d_rvalid", 32'(o_d_rvalid), 32'd0);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("ionly_i_pulse",  32'(o_i_rvalid), 32'd0);

    // D masked write, then read back the merged word
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b1, 11'h020, 32'h11223344, 4'b0011, 1'b1, 1'b0);
    checkOutput("dwr_d_ready",   32'(o_d_ready),  32'd1);
    checkOutput("dwr_i_ready",   32'(o_i_ready),  32'd0);
    checkOutput("dwr_mem_addr",  32'(o_mem_addr), 32'h020);
    checkOutput("dwr_mem_wdata", o_mem_wdata,     32'h11223344);
    checkOutput("dwr_mem_mask",  32'(o_mem_mask), 32'h3);
    checkOutput("dwr_mem_wren",  32'(o_mem_wren), 32'd1);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("dwr_d_rvalid",  32'(o_d_rvalid), 32'd1);
    checkOutput("dwr_d_rdata",   o_d_rdata,       32'h0);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b1, 11'h020, 32'h0, 4'hF, 1'b0, 1'b0);
    checkOutput("drd_mem_wren",  32'(o_mem_wren), 32'd0);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("drd_d_rvalid",  32'(o_d_rvalid), 32'd1);
    checkOutput("drd_d_rdata",   o_d_rdata,       32'hAAAA3344);

    // Continuous conflict: D wins four times, then I by starvation
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b0, 1'b0);
      checkOutput($sformatf("starve_i_ready_c%0d", c), 32'(o_i_ready), 32'(c == 4));
      checkOutput($sformatf("starve_d_ready_c%0d", c), 32'(o_d_ready), 32'(c != 4));
      if (c == 1) checkOutput("starve_d_rdata_c1", o_d_rdata, 32'hAAAA3344);
      if (c == 5) begin
        checkOutput("starve_i_rvalid_c5", 32'(o_i_rvalid), 32'd1);
        checkOutput("starve_i_rdata_c5",  o_i_rdata,       32'hDEADBEEF);
      end
    end
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Locked sequence lock=1, (gap), lock=1, lock=0 with I waiting throughout
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b0, 1'b1);
    checkOutput("lock_c0_d_ready", 32'(o_d_ready), 32'd1);
    checkOutput("lock_c0_i_ready", 32'(o_i_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b0, 11'h020, 32'h0, 4'hF, 1'b0, 1'b1);
    checkOutput("lock_gap_i_ready", 32'(o_i_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b0, 1'b1);
    checkOutput("lock_c2_d_ready", 32'(o_d_ready), 32'd1);
    checkOutput("lock_c2_i_ready", 32'(o_i_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b0, 1'b0);
    checkOutput("lock_c3_d_ready", 32'(o_d_ready), 32'd1);
    checkOutput("lock_c3_i_ready", 32'(o_i_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("lock_after_i_ready", 32'(o_i_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // D holds lock: 8 locked cycles, then I wins and D's lock is ignored
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b0, 1'b1);
      checkOutput($sformatf("force_i_ready_c%0d", c), 32'(o_i_ready), 32'(c == 9));
      checkOutput($sformatf("force_d_ready_c%0d", c), 32'(o_d_ready), 32'(c != 9));
    end

    // Reset while locked with a D response pending
    applyStimulus(1'b0, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b1, 1'b1);
    checkOutput("rstlk_pending",  32'(o_d_rvalid), 32'd1);
    checkOutput("rstlk_i_ready",  32'(o_i_ready),  32'd0);
    checkOutput("rstlk_d_ready",  32'(o_d_ready),  32'd0);
    checkOutput("rstlk_mem_wren", 32'(o_mem_wren), 32'd0);
    applyStimulus(1'b0, 1'b1, 11'h010, 1'b1, 11'h020, 32'h0, 4'hF, 1'b1, 1'b1);
    checkOutput("rstlk_d_rvalid", 32'(o_d_rvalid), 32'd0);
    checkOutput("rstlk_i_rvalid", 32'(o_i_rvalid), 32'd0);
    applyStimulus(1'b1, 1'b1, 11'h010, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("rstlk_idle_i_ready", 32'(o_i_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("rstlk_idle_i_rdata", o_i_rdata, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
